// File: rtl/l2_refill_ctrl.sv
// Request-side controller in front of a direct-mapped L2: probes the array,
// returns hits, refills misses from memory and forwards writes through to memory.
module l2_refill_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_addr,
  input  logic             req_we,
  input  logic [63:0]      req_wdata,
  output logic             resp_valid,
  output logic [63:0]      resp_data,
  output logic [63:0]      l2_addr,
  output logic             l2_we,
  output logic [63:0]      l2_wdata,
  input  logic [63:0]      l2_rdata,
  input  logic             l2_hit,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [63:0]      mem_req_addr,
  output logic             mem_req_we,
  output logic [63:0]      mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_data,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_HIT_RD   = 3'd2;
  localparam logic [2:0] S_MEM_REQ  = 3'd3;
  localparam logic [2:0] S_MEM_WAIT = 3'd4;
  localparam logic [2:0] S_FILL     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      fill_q, fill_d;
  logic             resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] misses_q, misses_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    fill_d       = fill_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // Writes always go through to memory, whether or not the line is resident.
        if (we_q) begin
          state_d = S_MEM_REQ;
        end else if (l2_hit) begin
          hits_d  = hits_q + 1'b1;
          state_d = S_HIT_RD;
        end else begin
          misses_d = misses_q + 1'b1;
          state_d  = S_MEM_REQ;
        end
      end
      S_HIT_RD: begin
        resp_data_d  = l2_rdata;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          if (we_q) begin
            resp_data_d  = 64'd0;
            resp_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) begin
          fill_d  = mem_resp_data;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        resp_data_d  = fill_q;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      fill_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      fill_q       <= fill_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign l2_addr       = addr_q;
  assign l2_we         = ((state_q == S_LOOKUP) && we_q) || (state_q == S_FILL);
  assign l2_wdata      = (state_q == S_FILL) ? fill_q : wdata_q;
  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_we    = (state_q == S_MEM_REQ) && we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Directed bench for l2_refill_ctrl; counters built narrow so wrap-around is reachable.
module tb_l2_refill_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_addr;
  logic             req_we;
  logic [63:0]      req_wdata;
  logic             resp_valid;
  logic [63:0]      resp_data;
  logic [63:0]      l2_addr;
  logic             l2_we;
  logic [63:0]      l2_wdata;
  logic [63:0]      l2_rdata;
  logic             l2_hit;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [63:0]      mem_req_addr;
  logic             mem_req_we;
  logic [63:0]      mem_req_wdata;
  logic             mem_resp_valid;
  logic [63:0]      mem_resp_data;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_misses;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int l2we_cnt = 0;
  int memhs_cnt = 0;

  l2_refill_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .l2_addr(l2_addr), .l2_we(l2_we), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_hit(l2_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (resp_valid) resp_cnt++;
      if (l2_we) l2we_cnt++;
      if (mem_req_valid && mem_req_ready) memhs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
    l2_rdata = '0; l2_hit = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    repeat (2) tick();
    checks++;
    if ({resp_valid, l2_we, mem_req_valid, mem_req_we} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {resp_valid, l2_we, mem_req_valid, mem_req_we});
    end
    checks++;
    if ((resp_data | l2_addr | l2_wdata | mem_req_addr | mem_req_wdata) !== 64'd0) begin
      errors++; $display("FAIL reset_data got nonzero bus %h exp 0", resp_data | l2_addr | l2_wdata);
    end
    checks++;
    if (stat_hits !== 0 || stat_misses !== 0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stat_hits, stat_misses);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_read_miss();
    int hs0;
    hs0 = memhs_cnt;
    l2_hit = 1'b0; mem_req_ready = 1'b1;
    req_valid = 1'b1; req_addr = 64'h40; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || l2_addr !== 64'h40 || l2_we !== 1'b0) begin
      errors++; $display("FAIL miss_c1 got rdy=%b addr=%h we=%b exp 0/40/0", req_ready, l2_addr, l2_we);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h40 || mem_req_we !== 1'b0) begin
      errors++; $display("FAIL miss_memreq got v=%b a=%h we=%b exp 1/40/0", mem_req_valid, mem_req_addr, mem_req_we);
    end
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    checks++;
    if (l2_we !== 1'b1 || l2_wdata !== 64'hDEAD_BEEF || resp_valid !== 1'b0) begin
      errors++; $display("FAIL miss_fill got we=%b wd=%h rv=%b exp 1/deadbeef/0", l2_we, l2_wdata, resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hDEAD_BEEF || req_ready !== 1'b1) begin
      errors++; $display("FAIL miss_resp got rv=%b d=%h rdy=%b exp 1/deadbeef/1", resp_valid, resp_data, req_ready);
    end
    checks++;
    if (stat_misses !== 4'd1 || stat_hits !== 4'd0 || memhs_cnt - hs0 !== 1) begin
      errors++; $display("FAIL miss_stats got m=%0d h=%0d hs=%0d exp 1/0/1", stat_misses, stat_hits, memhs_cnt - hs0);
    end
    mem_req_ready = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL miss_pulse got %b exp 0", resp_valid);
    end
  endtask

  task automatic test_read_hit();
    int hs0;
    hs0 = memhs_cnt;
    l2_hit = 1'b1; l2_rdata = 64'hDEAD_BEEF; mem_req_ready = 1'b1;
    req_valid = 1'b1; req_addr = 64'h40; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL hit_c2 got mv=%b rv=%b exp 0/0", mem_req_valid, resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hDEAD_BEEF || req_ready !== 1'b1) begin
      errors++; $display("FAIL hit_c3 got rv=%b d=%h rdy=%b exp 1/deadbeef/1", resp_valid, resp_data, req_ready);
    end
    checks++;
    if (stat_hits !== 4'd1 || stat_misses !== 4'd1 || memhs_cnt !== hs0) begin
      errors++; $display("FAIL hit_stats got h=%0d m=%0d hs=%0d exp 1/1/%0d", stat_hits, stat_misses, memhs_cnt, hs0);
    end
    mem_req_ready = 1'b0; l2_hit = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int bad;
    bad = 0;
    l2_hit = 1'b0; mem_req_ready = 1'b0;
    req_valid = 1'b1; req_addr = 64'h80; req_we = 1'b1; req_wdata = 64'h1234;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
    checks++;
    if (l2_we !== 1'b1 || l2_wdata !== 64'h1234 || l2_addr !== 64'h80) begin
      errors++; $display("FAIL wr_l2 got we=%b wd=%h a=%h exp 1/1234/80", l2_we, l2_wdata, l2_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 64'h80 ||
          mem_req_wdata !== 64'h1234 || l2_we !== 1'b0 || resp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wr_hold got %0d bad cycles exp 0", bad);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'd0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL wr_ack got rv=%b d=%h mv=%b exp 1/0/0", resp_valid, resp_data, mem_req_valid);
    end
    checks++;
    if (stat_hits !== 4'd1 || stat_misses !== 4'd1) begin
      errors++; $display("FAIL wr_stats got h=%0d m=%0d exp 1/1", stat_hits, stat_misses);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = resp_cnt;
    l2_hit = 1'b1; l2_rdata = 64'hAAAA;
    req_valid = 1'b1; req_addr = 64'h100; req_we = 1'b0;
    tick();
    req_addr = 64'h200;
    tick();
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hAAAA || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got rv=%b d=%h rdy=%b exp 1/aaaa/1", resp_valid, resp_data, req_ready);
    end
    tick();
    req_valid = 1'b0; l2_rdata = 64'hBBBB;
    checks++;
    if (req_ready !== 1'b0 || l2_addr !== 64'h200 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got rdy=%b a=%h rv=%b exp 0/200/0", req_ready, l2_addr, resp_valid);
    end
    tick();
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 64'hBBBB) begin
      errors++; $display("FAIL b2b_second got rv=%b d=%h exp 1/bbbb", resp_valid, resp_data);
    end
    tick();
    tick();
    checks++;
    if (resp_cnt - r0 !== 2 || stat_hits !== 4'd3) begin
      errors++; $display("FAIL b2b_count got resp=%0d h=%0d exp 2/3", resp_cnt - r0, stat_hits);
    end
    l2_hit = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r0;
    int w0;
    l2_hit = 1'b0; mem_req_ready = 1'b1;
    req_valid = 1'b1; req_addr = 64'h300; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, l2_we, mem_req_valid, mem_req_we} !== 4'b0 || l2_addr !== 64'd0 ||
        stat_misses !== 4'd0 || stat_hits !== 4'd0) begin
      errors++; $display("FAIL rstmid_out got ctrl=%b a=%h m=%0d h=%0d exp 0", {resp_valid, l2_we, mem_req_valid, mem_req_we}, l2_addr, stat_misses, stat_hits);
    end
    tick();
    rst_n = 1'b1;
    r0 = resp_cnt; w0 = l2we_cnt;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 64'h5555;
    tick();
    tick();
    mem_resp_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (resp_cnt !== r0 || l2we_cnt !== w0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_stale got resp=%0d we=%0d rdy=%b exp %0d/%0d/1", resp_cnt, l2we_cnt, req_ready, r0, w0);
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic do_miss(input logic [63:0] a);
    int budget;
    l2_hit = 1'b0; mem_req_ready = 1'b1;
    req_valid = 1'b1; req_addr = a; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = a;
    tick();
    mem_resp_valid = 1'b0;
    budget = 0;
    while (resp_valid !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== a) begin
      errors++; $display("FAIL wrap_resp got rv=%b d=%h exp 1/%h", resp_valid, resp_data, a);
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) do_miss(64'h1000 + 64'(i));
    checks++;
    if (stat_misses !== 4'd15) begin
      errors++; $display("FAIL wrap_pre got %0d exp 15", stat_misses);
    end
    do_miss(64'h2000);
    checks++;
    if (stat_misses !== 4'd0 || stat_hits !== 4'd0) begin
      errors++; $display("FAIL wrap_zero got m=%0d h=%0d exp 0/0", stat_misses, stat_hits);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
